// File: rtl/jtkcpu_fetch.sv
// Instruction prefetch unit: keeps a small byte queue filled from memory ahead of
// the decoder and handles relative/absolute redirects, including reads in flight.
module jtkcpu_fetch #(
   parameter int AW     = 16,
   parameter int QDEPTH = 4,
   parameter int QW     = $clog2(QDEPTH) + 1
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          halt,
   input  logic          op_rd,
   input  logic          br8,
   input  logic          br16,
   input  logic          jmp,
   input  logic [15:0]   data,
   input  logic [7:0]    mem_din,
   input  logic          mem_ok,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    op_dout,
   output logic          op_vld,
   output logic [AW-1:0] pc,
   output logic [QW-1:0] qlevel
);

   localparam int PW = $clog2(QDEPTH);

   typedef enum logic [1:0] { IDLE, WAIT, DROP } state_t;

   state_t          st;
   logic [7:0]      q [QDEPTH];
   logic [PW-1:0]   rptr, wptr;
   logic [AW-1:0]   faddr, target, off8, off16;
   logic            redir, push, pop, full;

   always_comb begin
      off8   = AW'($signed(data[7:0]));
      off16  = AW'($signed(data));
      target = pc + off8;
      if (jmp)       target = AW'(data);
      else if (br16) target = pc + off16;
      redir  = jmp | br16 | br8;
      // a redirect wins over both the returning byte and the decoder's pop
      push   = (st == WAIT) && mem_ok && !redir;
      pop    = op_rd && op_vld && !redir;
      full   = qlevel == QW'(QDEPTH);
   end

   assign op_vld  = qlevel != '0;
   assign op_dout = q[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         pc       <= '0;
         faddr    <= '0;
         qlevel   <= '0;
         rptr     <= '0;
         wptr     <= '0;
      end else if (cen) begin
         if (redir) begin
            pc     <= target;
            faddr  <= target;
            qlevel <= '0;
            rptr   <= '0;
            wptr   <= '0;
         end else begin
            if (pop) begin
               rptr <= rptr + 1'b1;
               pc   <= pc + 1'b1;
            end
            if (push) begin
               q[wptr] <= mem_din;
               wptr    <= wptr + 1'b1;
               faddr   <= faddr + 1'b1;
            end
            if (push && !pop)      qlevel <= qlevel + 1'b1;
            else if (pop && !push) qlevel <= qlevel - 1'b1;
         end
         case (st)
            IDLE: begin
               // a redirect launches the read of its target straight away
               if (redir) begin
                  if (!halt) begin
                     st       <= WAIT;
                     mem_rd   <= 1'b1;
                     mem_addr <= target;
                  end
               end else if (!full && !halt) begin
                  st       <= WAIT;
                  mem_rd   <= 1'b1;
                  mem_addr <= faddr;
               end
            end
            WAIT: begin
               if (mem_ok) begin
                  st     <= IDLE;
                  mem_rd <= 1'b0;
               end else if (redir) begin
                  st <= DROP;
               end
            end
            DROP: begin
               if (mem_ok) begin
                  st     <= IDLE;
                  mem_rd <= 1'b0;
               end
            end
            default: begin
               st     <= IDLE;
               mem_rd <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtkcpu_fetch.sv
// Directed bench for jtkcpu_fetch: stimulus queues expected reads/pops, monitors
// compare them as the DUT completes memory handshakes and decoder pops.
module tb_jtkcpu_fetch;

   logic        clk = 1'b0, rst = 1'b1, cen = 1'b1, halt = 1'b0, op_rd = 1'b0;
   logic        br8 = 1'b0, br16 = 1'b0, jmp = 1'b0;
   logic [15:0] data = '0;
   logic        ok_auto = 1'b0, ok_man = 1'b0, auto_en = 1'b0;
   logic [7:0]  din_auto = '0, din_man = '0;
   logic        mem_ok;
   logic [7:0]  mem_din;
   logic        mem_rd, op_vld;
   logic [15:0] mem_addr, pc;
   logic [7:0]  op_dout;
   logic [2:0]  qlevel;

   int tests = 0, fails = 0, npop = 0;
   logic [15:0] exp_addr[$];
   logic [23:0] exp_pop[$];

   assign mem_ok  = ok_auto | ok_man;
   assign mem_din = ok_man ? din_man : din_auto;

   jtkcpu_fetch #(.AW(16), .QDEPTH(4)) dut (
      .rst(rst), .clk(clk), .cen(cen), .halt(halt), .op_rd(op_rd),
      .br8(br8), .br16(br16), .jmp(jmp), .data(data),
      .mem_din(mem_din), .mem_ok(mem_ok), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .op_dout(op_dout), .op_vld(op_vld), .pc(pc), .qlevel(qlevel)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] f(input logic [15:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic settle(input int n);
      repeat (n) step();
   endtask

   task automatic redir(input logic j, input logic b16, input logic b8, input logic [15:0] d);
      jmp = j; br16 = b16; br8 = b8; data = d;
      step();
      jmp = 1'b0; br16 = 1'b0; br8 = 1'b0;
   endtask

   task automatic pops(input int n);
      int target;
      target = npop + n;
      op_rd = 1'b1;
      for (int i = 0; i < 80 && npop < target; i++) step();
      op_rd = 1'b0;
      if (npop < target) chk("pop_timeout", 32'(npop), 32'(target));
   endtask

   // memory model: answers each request one cycle later when enabled
   initial forever begin
      @(posedge clk); #1;
      if (auto_en && mem_rd && !ok_auto) begin
         ok_auto  = 1'b1;
         din_auto = f(mem_addr);
      end else ok_auto = 1'b0;
   end

   always @(negedge clk) begin
      if (!rst && cen) begin
         if (mem_rd && mem_ok) begin
            if (exp_addr.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_read: got %h expected none", mem_addr);
            end else chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
         end
         if (op_rd && op_vld && !(jmp | br16 | br8)) begin
            if (exp_pop.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_pop: got %h expected none", pc);
            end else begin
               logic [23:0] e;
               e = exp_pop.pop_front();
               chk("pop_pc", 32'(pc), 32'(e[23:8]));
               chk("pop_byte", 32'(op_dout), 32'(e[7:0]));
            end
            npop++;
         end
      end
   end

   initial begin
      #300000;
      fails++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

   initial begin
      settle(2);
      @(negedge clk);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_qlevel", 32'(qlevel), 0);
      chk("rst_op_vld", 32'(op_vld), 0);
      chk("rst_mem_rd", 32'(mem_rd), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);

      // fill
      for (int a = 0; a < 4; a++) exp_addr.push_back(16'(a));
      auto_en = 1'b1;
      step(); rst = 1'b0;
      settle(14); @(negedge clk);
      chk("fill_qlevel", 32'(qlevel), 4);
      chk("fill_mem_rd", 32'(mem_rd), 0);
      chk("fill_head", 32'(op_dout), 32'(f(16'h0000)));

      // stream twice: pc 0..8 then 8..16
      for (int blk = 0; blk < 2; blk++) begin
         for (int a = 0; a < 8; a++) exp_pop.push_back({16'(blk*8 + a), f(16'(blk*8 + a))});
         for (int a = 4; a < 12; a++) exp_addr.push_back(16'(blk*8 + a));
         step(); pops(8);
         settle(14); @(negedge clk);
         chk("stream_pc", 32'(pc), 32'((blk+1)*8));
         chk("stream_qlevel", 32'(qlevel), 4);
      end

      // short branch backwards, op_rd overridden
      for (int a = 0; a < 4; a++) exp_addr.push_back(16'(a));
      step(); op_rd = 1'b1;
      redir(1'b0, 1'b0, 1'b1, 16'h00F0);
      op_rd = 1'b0;
      @(negedge clk);
      chk("br8_pc", 32'(pc), 32'h0000);
      chk("br8_qlevel", 32'(qlevel), 0);
      chk("br8_op_vld", 32'(op_vld), 0);
      chk("br8_mem_rd", 32'(mem_rd), 1);
      settle(14); @(negedge clk);
      chk("br8_refill", 32'(qlevel), 4);

      // jump to FFF0, long branch wrapping to 0010
      for (int a = 0; a < 4; a++) exp_addr.push_back(16'hFFF0 + 16'(a));
      step(); redir(1'b1, 1'b0, 1'b0, 16'hFFF0);
      settle(14); @(negedge clk);
      chk("jmp_pc", 32'(pc), 32'hFFF0);
      for (int a = 0; a < 4; a++) exp_addr.push_back(16'h0010 + 16'(a));
      step(); redir(1'b0, 1'b1, 1'b0, 16'h0020);
      @(negedge clk);
      chk("br16_pc", 32'(pc), 32'h0010);
      settle(14);

      // jmp beats br8
      for (int a = 0; a < 4; a++) exp_addr.push_back(16'h1234 + 16'(a));
      step(); redir(1'b1, 1'b0, 1'b1, 16'h1234);
      @(negedge clk);
      chk("prio_pc", 32'(pc), 32'h1234);
      settle(14);
      exp_pop.push_back({16'h1234, f(16'h1234)});
      exp_addr.push_back(16'h1238);
      step(); pops(1);
      settle(14); @(negedge clk);
      chk("pop1_pc", 32'(pc), 32'h1235);
      chk("pop1_qlevel", 32'(qlevel), 4);

      // redirect during a pending read of 0005
      auto_en = 1'b0;
      step(); redir(1'b1, 1'b0, 1'b0, 16'h0005);
      @(negedge clk);
      chk("drop_rd5", 32'(mem_rd), 1);
      chk("drop_addr5", 32'(mem_addr), 32'h0005);
      step(); redir(1'b1, 1'b0, 1'b0, 16'h4000);
      @(negedge clk);
      chk("drop_hold_rd", 32'(mem_rd), 1);
      chk("drop_pc", 32'(pc), 32'h4000);
      step(); step();
      exp_addr.push_back(16'h0005);
      ok_man = 1'b1; din_man = 8'hEE;
      step(); ok_man = 1'b0;
      @(negedge clk);
      chk("drop_discard", 32'(qlevel), 0);
      chk("drop_rd_low", 32'(mem_rd), 0);
      step(); @(negedge clk);
      chk("drop_next_rd", 32'(mem_rd), 1);
      chk("drop_next_addr", 32'(mem_addr), 32'h4000);

      // mem_ok coincident with redirect
      step();
      exp_addr.push_back(16'h4000);
      ok_man = 1'b1; din_man = 8'hEE;
      redir(1'b1, 1'b0, 1'b0, 16'h5000);
      ok_man = 1'b0;
      @(negedge clk);
      chk("coin_qlevel", 32'(qlevel), 0);
      chk("coin_mem_rd", 32'(mem_rd), 0);
      chk("coin_pc", 32'(pc), 32'h5000);
      step(); @(negedge clk);
      chk("coin_next_addr", 32'(mem_addr), 32'h5000);

      // clock enable stall
      step();
      cen = 1'b0; ok_man = 1'b1; din_man = 8'h77; op_rd = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(); @(negedge clk);
         chk("stall_mem_rd", 32'(mem_rd), 1);
         chk("stall_addr", 32'(mem_addr), 32'h5000);
         chk("stall_qlevel", 32'(qlevel), 0);
      end

      // halt does not abort the pending read
      step();
      cen = 1'b1; op_rd = 1'b0; halt = 1'b1;
      exp_addr.push_back(16'h5000);
      step(); ok_man = 1'b0;
      @(negedge clk);
      chk("halt_qlevel", 32'(qlevel), 1);
      chk("halt_head", 32'(op_dout), 32'h77);
      settle(3); @(negedge clk);
      chk("halt_no_rd", 32'(mem_rd), 0);
      step(); halt = 1'b0;
      step(); @(negedge clk);
      chk("unhalt_addr", 32'(mem_addr), 32'h5001);
      chk("unhalt_rd", 32'(mem_rd), 1);

      // reset while a read is outstanding
      step(); rst = 1'b1;
      step(); rst = 1'b0; halt = 1'b1;
      @(negedge clk);
      chk("wrst_pc", 32'(pc), 0);
      chk("wrst_qlevel", 32'(qlevel), 0);
      chk("wrst_op_vld", 32'(op_vld), 0);
      chk("wrst_mem_rd", 32'(mem_rd), 0);
      chk("wrst_mem_addr", 32'(mem_addr), 0);
      step(); ok_man = 1'b1; din_man = 8'h99;
      step(); ok_man = 1'b0;
      @(negedge clk);
      chk("late_ok_ignored", 32'(qlevel), 0);

      chk("addr_q_empty", 32'(exp_addr.size()), 0);
      chk("pop_q_empty", 32'(exp_pop.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jtkcpu_fetch.md
JTKCPU_FETCH -- requirements
Module: jtkcpu_fetch

Interface
REQ-001 Parameter AW, default 16, is the program counter and fetch address width; legal range 16..24.
REQ-002 Parameter QDEPTH, default 4, is the prefetch queue depth in bytes; it SHALL be a power of two in 2..16.
REQ-003 Parameter QW, default $clog2(QDEPTH)+1, is the width of the queue level count.
REQ-004 Clocking and reset SHALL use one clock and a synchronous, active-high reset, with ports named as the codebase does: rst, clk, cen.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 clk  in  1  system clock.
REQ-007 cen  in  1  clock enable; all state advances only when cen=1.
REQ-008 halt  in  1  inhibits new memory read requests.
REQ-009 op_rd  in  1  decoder consumes the head byte of the queue.
REQ-010 br8  in  1  short relative redirect request.
REQ-011 br16  in  1  long relative redirect request.
REQ-012 jmp  in  1  absolute redirect request.
REQ-013 data  in  16  branch offset or jump target.
REQ-014 mem_din  in  8  read data from memory.
REQ-015 mem_ok  in  1  mem_din is valid for the outstanding read.
REQ-016 mem_rd  out  1  read request; held high until mem_ok.
REQ-017 mem_addr  out  AW  read address.
REQ-018 op_dout  out  8  head byte of the queue.
REQ-019 op_vld  out  1  queue is not empty.
REQ-020 pc  out  AW  address of the head byte, or of the next byte to be delivered.
REQ-021 qlevel  out  QW  number of bytes held in the queue.

Function
REQ-022 Internal state SHALL consist of the pc, the fetch address faddr, a circular byte queue with read/write pointers and a count, and a fetch FSM with states IDLE, WAIT and DROP.
REQ-023 In IDLE, when qlevel < QDEPTH, halt=0 and there is no redirect this cycle, the FSM SHALL move to WAIT with mem_rd=1 and mem_addr=faddr; only one read SHALL ever be outstanding.
REQ-024 In WAIT, mem_ok=1 SHALL push mem_din into the queue, increment faddr modulo 2^AW, and return the FSM to IDLE.
REQ-025 When op_rd=1 and op_vld=1, the queue SHALL pop one byte and pc SHALL increment modulo 2^AW; op_rd with op_vld=0 SHALL be ignored.
REQ-026 A push and a pop in the same cycle SHALL leave qlevel unchanged, including when the queue is full.
REQ-027 Redirect priority SHALL be jmp > br16 > br8; a redirect in a cycle SHALL override op_rd in that cycle.
REQ-028 Redirect targets SHALL be:
- br8: pc + sign-extended data[7:0];
- br16: pc + sign-extended data[15:0];
- jmp: data zero-extended to AW.
All arithmetic is modulo 2^AW, and pc is the value before the redirect cycle.
REQ-029 On redirect: queue flushed (qlevel=0, op_vld=0 next cycle), pc=target, faddr=target.
REQ-030 A redirect while in WAIT SHALL move the FSM to DROP; mem_rd SHALL stay high until mem_ok, and the returned byte SHALL be discarded before the FSM enters IDLE.
REQ-031 mem_ok arriving in the same cycle as a redirect SHALL be discarded, and the FSM SHALL go to IDLE.
REQ-032 A redirect in DROP SHALL only update pc and faddr again; the FSM SHALL remain in DROP.
REQ-033 Latency SHALL be:
- redirect from IDLE: mem_rd=1 with the new address in the next cycle;
- mem_ok: op_vld=1 in the next cycle.
REQ-034 halt=1 SHALL NOT abort an outstanding read and SHALL NOT block op_rd or redirects.
REQ-035 With cen=0, all registers SHALL hold and the outputs SHALL remain stable.
REQ-036 op_dout SHALL be driven from the queue head combinationally; it is don't-care when op_vld=0.

Reset
REQ-037 rst=1 SHALL set pc=0, faddr=0, qlevel=0, op_vld=0, mem_rd=0, mem_addr=0 and the FSM to IDLE, regardless of cen.
REQ-038 Reset during WAIT or DROP SHALL abandon the outstanding read; a mem_ok arriving after reset SHALL be ignored unless a new read has been issued.

Verification
REQ-039 Fill: with AW=16, QDEPTH=4 and mem_ok one cycle after each mem_rd, and no op_rd:
- mem_addr steps 0,1,2,3;
- qlevel reaches 4;
- mem_rd stays 0 afterwards.
REQ-040 Stream: with the queue full, hold op_rd=1 for 8 cycles. The bytes are delivered in address order, pc advances 0..8, and no byte is lost or duplicated.
REQ-041 Short branch: with pc=0x0010, apply br8=1, data=0x00F0. Then pc=0x0000, the queue is flushed, and the next mem_addr=0x0000.
REQ-042 Long branch and jump: with pc=0xFFF0, br16 with data=0x0020 gives pc=0x0010 (wrap-around). jmp and br8 in the same cycle with data=0x1234 give pc=0x1234.
REQ-043 Drop: a redirect to 0x4000 while a read of 0x0005 is pending.
- The late mem_ok byte is not enqueued.
- The next request is 0x4000.
- mem_ok coincident with the redirect is also discarded.
REQ-044 Stall and reset: cen=0 for 5 cycles freezes all outputs. halt=1 still completes the pending read. rst in WAIT returns every output to its reset value.
